// File: rtl/gpio_seq_if.sv
// Step push / GPIO write bus between the register block and gpio_seq.
//   master : register block side (pushes steps, reports software writes,
//            consumes step write requests)
//   slave  : gpio_seq side
interface gpio_seq_if #(
  parameter int N_GPIO  = 8,
  parameter int W_DELAY = 16
);
  logic               push_valid;
  logic               push_ready;
  logic [N_GPIO-1:0]  push_out;
  logic [N_GPIO-1:0]  push_oen;
  logic [W_DELAY-1:0] push_delay;
  logic               sw_wen;
  logic               step_wen;
  logic [N_GPIO-1:0]  step_out;
  logic [N_GPIO-1:0]  step_oen;

  modport master (
    output push_valid, push_out, push_oen, push_delay, sw_wen,
    input  push_ready, step_wen, step_out, step_oen
  );

  modport slave (
    input  push_valid, push_out, push_oen, push_delay, sw_wen,
    output push_ready, step_wen, step_out, step_oen
  );
endinterface

// File: rtl/gpio_seq.sv
// Timed pattern sequencer for the GPIO out/oen registers.
// Steps {out, oen, delay} are queued in a small FIFO and written to the GPIO
// registers at cycle-accurate intervals (accepted writes delay+2 cycles apart).
// Ports:
//   clk, rst_n      clock, async active-low reset
//   enable          run control (level); never truncates a step in flight
//   abort           flush FIFO, return to IDLE (highest priority)
//   clr_underrun    clears the sticky underrun flag (a same-cycle set wins)
//   busy            registered state != IDLE
//   level           registered FIFO occupancy
//   underrun        sticky: FIFO ran dry while enabled
//   bus (slave)     step push handshake, software write stall, step write out
module gpio_seq #(
  parameter int N_GPIO  = 8,
  parameter int W_DELAY = 16,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   abort,
  input  logic                   clr_underrun,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underrun,
  gpio_seq_if.slave              bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, WAIT = 2'd2} state_t;

  state_t                          state_q, state_d;
  logic [DEPTH-1:0][N_GPIO-1:0]    fout_q, fout_d;
  logic [DEPTH-1:0][N_GPIO-1:0]    foen_q, foen_d;
  logic [DEPTH-1:0][W_DELAY-1:0]   fdly_q, fdly_d;
  logic [AW-1:0]                   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]                   level_q, level_d;
  logic [W_DELAY-1:0]              cnt_q, cnt_d;
  logic                            underrun_q, underrun_d;
  logic                            busy_q, busy_d;
  logic                            full, empty, push_acc, pop, set_underrun;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // push_ready ignores a same-cycle pop so it is a pure function of level.
  assign bus.push_ready = !full;
  assign bus.step_wen   = (state_q == APPLY);
  assign bus.step_out   = empty ? '0 : fout_q[rptr_q];
  assign bus.step_oen   = empty ? '0 : foen_q[rptr_q];

  assign push_acc = bus.push_valid && !full && !abort;
  // A step is accepted only in an APPLY cycle with no software write.
  assign pop      = (state_q == APPLY) && !bus.sw_wen && !abort;

  assign busy     = busy_q;
  assign level    = level_q;
  assign underrun = underrun_q;

  // Sequencer FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    set_underrun = 1'b0;
    case (state_q)
      IDLE:  if (enable && !empty) state_d = APPLY;
      APPLY: if (!bus.sw_wen) begin
        state_d = WAIT;
        cnt_d   = fdly_q[rptr_q];
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - W_DELAY'(1);
        end else if (enable) begin
          if (!empty) begin
            state_d = APPLY;
          end else begin
            state_d      = IDLE;
            set_underrun = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d      = IDLE;
      cnt_d        = '0;
      set_underrun = 1'b0;
    end
  end

  // Step FIFO
  always_comb begin
    fout_d  = fout_q;
    foen_d  = foen_q;
    fdly_d  = fdly_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (abort) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_acc) begin
        fout_d[wptr_q] = bus.push_out;
        foen_d[wptr_q] = bus.push_oen;
        fdly_d[wptr_q] = bus.push_delay;
        wptr_d         = wptr_q + AW'(1);
      end
      if (pop) rptr_d = rptr_q + AW'(1);
      case ({push_acc, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    underrun_d = underrun_q;
    if (set_underrun)      underrun_d = 1'b1;
    else if (clr_underrun) underrun_d = 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fout_q     <= '0;
      foen_q     <= '0;
      fdly_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fout_q     <= fout_d;
      foen_q     <= foen_d;
      fdly_q     <= fdly_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
    end
  end
endmodule

// File: doc/gpio_seq.md
Name: gpio_seq

Overview:
- Timed pattern sequencer for the GPIO output/output-enable registers.
- Software pushes steps into a small FIFO through the GPIO APB register block. Each step is an {out, oen, delay} triple.
- The sequencer writes steps into the GPIO output registers at cycle-accurate intervals, for bit-banged protocols that software cannot time reliably.
- Software write requests have priority over the sequencer: a sequencer write stalls while software writes the same registers.

Parameters:
- N_GPIO, 8, GPIO count; width of out/oen fields.
- W_DELAY, 16, width of per-step delay field.
- DEPTH, 4, step FIFO depth; power of two, ≥2.

Ports:
- clk  input  1  system clock (clk_sys); the only clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- enable  input  1  run control from register block; level.
- abort  input  1  single-cycle pulse; flush and return to IDLE.
- push_valid  input  1  step push strobe.
- push_ready  output  1  FIFO can accept a step; equals !full.
- push_out  input  N_GPIO  step output values.
- push_oen  input  N_GPIO  step output enables.
- push_delay  input  W_DELAY  step hold time.
- sw_wen  input  1  OR of all software out/oen write/xor/set/clr strobes this cycle.
- step_wen  output  1  request to load step_out/step_oen into gpio_out/gpio_oen.
- step_out  output  N_GPIO  FIFO head out field.
- step_oen  output  N_GPIO  FIFO head oen field.
- busy  output  1  state != IDLE.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- underrun  output  1  sticky flag: FIFO ran dry while enabled.
- clr_underrun  input  1  pulse; clears underrun.

Behaviour:
- Reset values: state IDLE, FIFO empty, level 0, push_ready 1, step_wen 0, busy 0, underrun 0, counter 0. step_out/step_oen read 0 while empty.
- Reset mid-operation discards the FIFO and any step in flight. The GPIO registers keep their last written values; they are owned by the gpio block's own reset.
- FIFO:
  - A push is accepted when push_valid && push_ready && !abort.
  - A pop occurs when a step is accepted (see APPLY).
  - Push and pop in the same cycle: level is unchanged.
  - When full, push_ready is 0 even if a pop happens in the same cycle.
  - Read/write pointers wrap modulo DEPTH. level is registered.
- States:
  - IDLE: step_wen=0. If enable && level!=0, next state is APPLY.
  - APPLY: step_wen=1, step_out/step_oen = FIFO head.
    - If sw_wen=1: stay in APPLY (retry next cycle); no pop, counter untouched. The gpio block must give software writes priority over step_wen.
    - If sw_wen=0: the step is accepted. Pop the FIFO, load counter with the head's delay, go to WAIT.
  - WAIT: step_wen=0.
    - If counter!=0: decrement.
    - If counter==0 and enable && level!=0: go to APPLY.
    - If counter==0 and enable && level==0: set underrun, go to IDLE.
    - If counter==0 and !enable: go to IDLE, underrun unchanged.
- Timing: with no stalls, the accepted APPLY cycles of consecutive steps are delay+2 cycles apart. With delay=0 they are 2 cycles apart.
- Latency: from enable rising with a non-empty FIFO, step_wen first asserts 1 cycle later (IDLE→APPLY).
- Deasserting enable never truncates a step: the current APPLY/WAIT completes, then the block goes to IDLE with the FIFO contents kept.
- abort (highest priority, any state):
  - Next state IDLE; FIFO flushed, level 0; counter 0.
  - Any push in the same cycle is dropped.
  - step_wen still reads 1 combinationally in an APPLY abort cycle. The gpio block therefore qualifies it with !abort; abort is registered upstream, so this is a single gate.
- underrun: set only on the WAIT→IDLE transition with enable=1. If clr_underrun and a set event happen in the same cycle, set wins.
- Arithmetic: counter is W_DELAY bits, decrement only. It never wraps because the decrement is gated on !=0. A maximum delay of 2^W_DELAY-1 is legal.
- All outputs other than step_wen, step_out, step_oen and push_ready are registered. step_wen is decoded from the state register. step_out/step_oen are a mux of FIFO storage flops.

Test Plan:
- Basic sequence: push {out=0x01, oen=0xFF, delay=3}, {0x02, 0xFF, 0}, {0x04, 0xFF, 5}, then enable=1.
  - step_wen pulses at cycles t, t+5, t+7 with values 0x01, 0x02, 0x04.
  - Then IDLE with underrun=1 at t+14.
- Software stall: hold sw_wen=1 for 3 cycles during the first APPLY.
  - step_wen stays high 4 cycles with head 0x01; level stays 3 until accept.
  - All later steps are shifted by exactly 3 cycles.
- Full/backpressure: push 5 steps back-to-back with DEPTH=4 and enable=0.
  - push_ready=0 after the 4th; level=4; 5th push not accepted.
  - Enable: after the first accept, level=3 and push_ready=1.
- Abort: abort in WAIT with level=2, with push_valid=1 in the same cycle.
  - Next cycle: IDLE, level=0, busy=0, step_wen stays 0.
  - underrun=0; the pushed step is absent.
- Disable mid-step: enable=0 during WAIT of a step with delay=10, level=2.
  - The step finishes (11 WAIT cycles), then IDLE with level=2, underrun=0.
  - Re-enabling resumes with the next step.
- Underrun clear/set race: clr_underrun asserted in the same cycle as an underrun set → underrun=1. A later lone clr_underrun → 0.
- Reset: assert rst_n low mid-APPLY → all outputs return to reset values immediately (asynchronous).
